// File: rtl/radix2_divider_if.sv
// Handshake and operand/result bundle between the ALU (master) and the
// radix-2 divider (slave).
interface radix2_divider_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             busy;
   logic             valid;
   logic             dbz;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;

   modport master (
      output start, x, y,
      input  busy, valid, dbz, q, r
   );

   modport slave (
      input  start, x, y,
      output busy, valid, dbz, q, r
   );
endinterface

// File: rtl/radix2_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Divide-by-zero completes in one cycle with q = all ones, r = x.
// Optional macro DIV_SHORTCUT_EN: when x < y the result (q = 0, r = x) is
// produced in one cycle instead of running the full WIDTH-cycle loop.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; results from the last division are held
// CALC  | shifting/subtracting one quotient bit per clock
module radix2_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   radix2_divider_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE,
      CALC
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] qs;
   logic [WIDTH-1:0] ycap;
   logic [WIDTH:0]   p;
   logic [CNT_W-1:0] cnt;

   logic             busy;
   logic             valid;
   logic             dbz;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;

   logic [WIDTH:0]   p_shift;
   logic [WIDTH:0]   p_next;
   logic [WIDTH-1:0] qs_next;

   assign bus.busy  = busy;
   assign bus.valid = valid;
   assign bus.dbz   = dbz;
   assign bus.q     = q;
   assign bus.r     = r;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      p_shift = {p[WIDTH-1:0], qs[WIDTH-1]};
      qs_next = {qs[WIDTH-2:0], 1'b0};
      p_next  = p_shift;
      if (p_shift >= {1'b0, ycap}) begin
         p_next     = p_shift - {1'b0, ycap};
         qs_next[0] = 1'b1;
      end
   end

   // Control FSM and datapath registers; all outputs are registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         qs    <= '0;
         ycap  <= '0;
         p     <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         valid <= 1'b0;
         dbz   <= 1'b0;
         q     <= '0;
         r     <= '0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.y == '0) begin
                     q     <= '1;
                     r     <= bus.x;
                     dbz   <= 1'b1;
                     valid <= 1'b1;
                  end
`ifdef DIV_SHORTCUT_EN
                  else if (bus.x < bus.y) begin
                     q     <= '0;
                     r     <= bus.x;
                     dbz   <= 1'b0;
                     valid <= 1'b1;
                  end
`endif
                  else begin
                     qs    <= bus.x;
                     ycap  <= bus.y;
                     p     <= '0;
                     cnt   <= CNT_W'(WIDTH);
                     busy  <= 1'b1;
                     dbz   <= 1'b0;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               p   <= p_next;
               qs  <= qs_next;
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  q     <= qs_next;
                  r     <= p_next[WIDTH-1:0];
                  busy  <= 1'b0;
                  valid <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_radix2_divider.sv
// Directed and random checks of the radix-2 divider.
module tb_radix2_divider;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   radix2_divider_if #(.WIDTH(32)) bus ();

   radix2_divider #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Issue one start and wait for valid. lat = edges after the accepting edge
   // at which valid was seen (-1 on timeout); bcnt = cycles with busy high.
   task automatic launch(input logic [31:0] xa, input logic [31:0] ya,
                         output int lat, output int bcnt);
      @(negedge clk);
      bus.start = 1'b1;
      bus.x     = xa;
      bus.y     = ya;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.x     = $urandom;
      bus.y     = $urandom;
      lat  = -1;
      bcnt = 0;
      if (bus.valid) begin
         lat = 0;
      end else begin
         if (bus.busy) bcnt++;
         for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid) begin
               lat = i;
               break;
            end
            if (bus.busy) bcnt++;
         end
      end
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.x     = '0;
      bus.y     = '0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({bus.busy, bus.valid, bus.dbz} !== 3'b000 || bus.q !== 32'd0 || bus.r !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b valid=%b dbz=%b q=%h r=%h, want all 0",
                  bus.busy, bus.valid, bus.dbz, bus.q, bus.r);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      int lat, bcnt;
      launch(32'd100, 32'd7, lat, bcnt);
      n_tests++;
      if (lat !== 32 || bcnt !== 32) begin
         n_fail++;
         $display("FAIL basic_timing: lat=%0d busy_cycles=%0d, want 32/32", lat, bcnt);
      end
      n_tests++;
      if (bus.q !== 32'd14 || bus.r !== 32'd2 || bus.dbz !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_result: q=%0d r=%0d dbz=%b, want 14/2/0", bus.q, bus.r, bus.dbz);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.valid !== 1'b0 || bus.q !== 32'd14 || bus.r !== 32'd2) begin
         n_fail++;
         $display("FAIL valid_pulse_hold: valid=%b q=%0d r=%0d, want 0/14/2", bus.valid, bus.q, bus.r);
      end
   endtask

   task automatic test_div_zero;
      int lat, bcnt;
      launch(32'h1234, 32'd0, lat, bcnt);
      n_tests++;
      if (lat !== 0 || bcnt !== 0) begin
         n_fail++;
         $display("FAIL dbz_timing: lat=%0d busy_cycles=%0d, want 0/0", lat, bcnt);
      end
      n_tests++;
      if (bus.q !== 32'hFFFF_FFFF || bus.r !== 32'h1234 || bus.dbz !== 1'b1) begin
         n_fail++;
         $display("FAIL dbz_result: q=%h r=%h dbz=%b, want ffffffff/1234/1", bus.q, bus.r, bus.dbz);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.dbz !== 1'b1) begin
         n_fail++;
         $display("FAIL dbz_hold: valid=%b busy=%b dbz=%b, want 0/0/1", bus.valid, bus.busy, bus.dbz);
      end
   endtask

   task automatic test_extremes;
      int lat, bcnt;
      launch(32'hFFFF_FFFF, 32'd1, lat, bcnt);
      n_tests++;
      if (lat !== 32 || bus.q !== 32'hFFFF_FFFF || bus.r !== 32'd0 || bus.dbz !== 1'b0) begin
         n_fail++;
         $display("FAIL max_by_one: lat=%0d q=%h r=%h dbz=%b, want 32/ffffffff/0/0",
                  lat, bus.q, bus.r, bus.dbz);
      end
      launch(32'hFFFF_FFFF, 32'h0001_0000, lat, bcnt);
      n_tests++;
      if (lat !== 32 || bus.q !== 32'h0000_FFFF || bus.r !== 32'h0000_FFFF) begin
         n_fail++;
         $display("FAIL max_by_64k: lat=%0d q=%h r=%h, want 32/ffff/ffff", lat, bus.q, bus.r);
      end
      launch(32'd7, 32'd7, lat, bcnt);
      n_tests++;
      if (bus.q !== 32'd1 || bus.r !== 32'd0) begin
         n_fail++;
         $display("FAIL equal_operands: q=%0d r=%0d, want 1/0", bus.q, bus.r);
      end
   endtask

   task automatic test_ignore_start;
      int lat;
      @(negedge clk);
      bus.start = 1'b1;
      bus.x     = 32'd50;
      bus.y     = 32'd5;
      @(posedge clk);
      #1;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         bus.start = (i == 10);
         bus.x     = (i == 10) ? 32'd9 : $urandom;
         bus.y     = (i == 10) ? 32'd3 : $urandom;
         @(posedge clk);
         #1;
         if (bus.valid) begin
            lat = i;
            break;
         end
      end
      bus.start = 1'b0;
      n_tests++;
      if (lat !== 32 || bus.q !== 32'd10 || bus.r !== 32'd0) begin
         n_fail++;
         $display("FAIL start_while_busy: lat=%0d q=%0d r=%0d, want 32/10/0", lat, bus.q, bus.r);
      end
   endtask

   task automatic test_back_to_back;
      int lat, bcnt;
      launch(32'd1000, 32'd3, lat, bcnt);
      n_tests++;
      if (lat !== 32 || bus.q !== 32'd333 || bus.r !== 32'd1) begin
         n_fail++;
         $display("FAIL b2b_first: lat=%0d q=%0d r=%0d, want 32/333/1", lat, bus.q, bus.r);
      end
      launch(32'd12345, 32'd100, lat, bcnt);
      n_tests++;
      if (lat !== 32 || bcnt !== 32 || bus.q !== 32'd123 || bus.r !== 32'd45) begin
         n_fail++;
         $display("FAIL b2b_second: lat=%0d busy_cycles=%0d q=%0d r=%0d, want 32/32/123/45",
                  lat, bcnt, bus.q, bus.r);
      end
   endtask

   task automatic test_abort;
      int lat, bcnt;
      bit seen;
      @(negedge clk);
      bus.start = 1'b1;
      bus.x     = 32'd1000;
      bus.y     = 32'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (15) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({bus.busy, bus.valid, bus.dbz} !== 3'b000 || bus.q !== 32'd0 || bus.r !== 32'd0) begin
         n_fail++;
         $display("FAIL abort_clear: busy=%b valid=%b dbz=%b q=%h r=%h, want all 0",
                  bus.busy, bus.valid, bus.dbz, bus.q, bus.r);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.valid || bus.busy) seen = 1'b1;
      end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_no_valid: activity after reset=%b, want 0", seen);
      end
      launch(32'd9, 32'd2, lat, bcnt);
      n_tests++;
      if (lat !== 32 || bus.q !== 32'd4 || bus.r !== 32'd1) begin
         n_fail++;
         $display("FAIL after_abort: lat=%0d q=%0d r=%0d, want 32/4/1", lat, bus.q, bus.r);
      end
   endtask

   task automatic test_small_dividend;
      int lat, bcnt, exp_lat;
`ifdef DIV_SHORTCUT_EN
      exp_lat = 0;
`else
      exp_lat = 32;
`endif
      launch(32'd3, 32'd10, lat, bcnt);
      n_tests++;
      if (lat !== exp_lat || bcnt !== exp_lat) begin
         n_fail++;
         $display("FAIL x_lt_y_timing: lat=%0d busy_cycles=%0d, want %0d/%0d",
                  lat, bcnt, exp_lat, exp_lat);
      end
      n_tests++;
      if (bus.q !== 32'd0 || bus.r !== 32'd3 || bus.dbz !== 1'b0) begin
         n_fail++;
         $display("FAIL x_lt_y_result: q=%0d r=%0d dbz=%b, want 0/3/0", bus.q, bus.r, bus.dbz);
      end
   endtask

   task automatic test_random;
      int lat, bcnt;
      logic [31:0] xa, ya, eq, er;
      logic        ed;
      for (int n = 0; n < 150; n++) begin
         xa = $urandom;
         case (n % 5)
            0: ya = 32'd0;
            1: ya = $urandom_range(1, 20);
            2: ya = xa + 32'd1 + $urandom_range(0, 5);
            default: ya = $urandom >> $urandom_range(0, 31);
         endcase
         if (ya == 32'd0) begin
            eq = 32'hFFFF_FFFF;
            er = xa;
            ed = 1'b1;
         end else begin
            eq = xa / ya;
            er = xa % ya;
            ed = 1'b0;
         end
         launch(xa, ya, lat, bcnt);
         n_tests++;
         if (lat < 0 || bus.q !== eq || bus.r !== er || bus.dbz !== ed) begin
            n_fail++;
            $display("FAIL random %h/%h: lat=%0d q=%h r=%h dbz=%b, want q=%h r=%h dbz=%b",
                     xa, ya, lat, bus.q, bus.r, bus.dbz, eq, er, ed);
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_basic();
      test_div_zero();
      test_extremes();
      test_ignore_start();
      test_back_to_back();
      test_abort();
      test_small_dividend();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
